// File: rtl/map_tile_updater_if.sv
// Game-logic / renderer side bus of the battlefield tile updater.
// Master drives requests and read coordinates; slave returns handshake, results and tiles.
interface map_tile_updater_if;
  logic       init;
  logic       ld_we;
  logic [3:0] ld_x;
  logic [3:0] ld_y;
  logic [6:0] ld_tile;
  logic       hit_valid;
  logic       hit_ready;
  logic [3:0] hit_x;
  logic [3:0] hit_y;
  logic [3:0] hit_mask;
  logic       hit_heavy;
  logic       done;
  logic [1:0] result;
  logic       busy;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [6:0] rd_tile;

  modport master (
    output init, ld_we, ld_x, ld_y, ld_tile,
    output hit_valid, hit_x, hit_y, hit_mask, hit_heavy,
    output rd_x, rd_y,
    input  hit_ready, done, result, busy, rd_tile
  );

  modport slave (
    input  init, ld_we, ld_x, ld_y, ld_tile,
    input  hit_valid, hit_x, hit_y, hit_mask, hit_heavy,
    input  rd_x, rd_y,
    output hit_ready, done, result, busy, rd_tile
  );
endinterface

// File: rtl/map_tile_updater.sv
// Writable 13x13 tile store: bullet-hit damage, direct level loads, bulk clear, and a
// combinational renderer read port. Tile word = {type[2:0], state[3:0]}.
//
// state  | meaning
// IDLE   | waiting; init > load > hit priority, hit_ready only here
// CLEAR  | writing {AIR,1111} to one tile per cycle in raster order
// LOOKUP | evaluating the latched hit against the stored tile
// WRITE  | committing the damaged tile, pulsing done with the result
module map_tile_updater #(
  parameter int MAP_W     = 13,
  parameter int MAP_H     = 13,
  parameter int TILE_BITS = 7
) (
  input logic               clk_i,
  input logic               rst_ni,
  map_tile_updater_if.slave bus
);

  localparam int N_TILES = MAP_W * MAP_H;
  localparam int IDX_W   = $clog2(N_TILES);

  localparam logic [3:0]       W4       = 4'(MAP_W);
  localparam logic [3:0]       H4       = 4'(MAP_H);
  localparam logic [IDX_W-1:0] W_IDX    = IDX_W'(MAP_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);

  localparam logic [2:0] T_BRICK = 3'b000;
  localparam logic [2:0] T_WALL  = 3'b001;
  localparam logic [2:0] T_AIR   = 3'b111;

  localparam logic [TILE_BITS-1:0] TILE_AIR  = {T_AIR, 4'b1111};
  localparam logic [TILE_BITS-1:0] TILE_VOID = {T_AIR, 4'b0000};

  localparam logic [1:0] R_PASS      = 2'b00;
  localparam logic [1:0] R_DAMAGED   = 2'b01;
  localparam logic [1:0] R_DESTROYED = 2'b10;
  localparam logic [1:0] R_BLOCKED   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_LOOKUP = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  function automatic logic in_range(input logic [3:0] x, input logic [3:0] y);
    return (x < W4) && (y < H4);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [3:0] x, input logic [3:0] y);
    return IDX_W'(y) * W_IDX + IDX_W'(x);
  endfunction

  logic [TILE_BITS-1:0] tiles [N_TILES];
  logic [1:0]           state;
  logic [IDX_W-1:0]     clr_idx;
  logic [3:0]           hx, hy, hmask;
  logic                 hheavy;
  logic                 wr_pend;
  logic [TILE_BITS-1:0] wr_tile;
  logic [1:0]           res_pend;
  logic                 done_q;
  logic [1:0]           result_q;

  logic [TILE_BITS-1:0] lk_tile;
  logic [TILE_BITS-1:0] nxt_tile;
  logic [1:0]           nxt_res;
  logic                 nxt_wr;
  logic [3:0]           new_state;

  assign bus.hit_ready = rst_ni && (state == ST_IDLE) && !bus.init && !bus.ld_we;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.rd_tile   = in_range(bus.rd_x, bus.rd_y) ? tiles[idx_of(bus.rd_x, bus.rd_y)]
                                                      : TILE_VOID;

  // A heavy shot on a wall damages it like a brick; the tile keeps its own type.
  always_comb begin
    lk_tile   = tiles[idx_of(hx, hy)];
    nxt_tile  = lk_tile;
    nxt_res   = R_PASS;
    nxt_wr    = 1'b0;
    new_state = lk_tile[3:0] & ~hmask;
    if (in_range(hx, hy)) begin
      if (lk_tile[6:4] == T_WALL && !hheavy) begin
        nxt_res = R_BLOCKED;
      end else if ((lk_tile[6:4] == T_BRICK || lk_tile[6:4] == T_WALL) && hmask != 4'b0000) begin
        if (new_state == 4'b0000) begin
          nxt_tile = TILE_AIR;
          nxt_res  = R_DESTROYED;
          nxt_wr   = 1'b1;
        end else if (new_state != lk_tile[3:0]) begin
          nxt_tile = {lk_tile[6:4], new_state};
          nxt_res  = R_DAMAGED;
          nxt_wr   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      clr_idx  <= '0;
      hx       <= '0;
      hy       <= '0;
      hmask    <= '0;
      hheavy   <= 1'b0;
      wr_pend  <= 1'b0;
      wr_tile  <= '0;
      res_pend <= R_PASS;
      done_q   <= 1'b0;
      result_q <= R_PASS;
      for (int i = 0; i < N_TILES; i++) tiles[i] <= TILE_AIR;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.init) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
          end else if (bus.ld_we) begin
            if (in_range(bus.ld_x, bus.ld_y)) tiles[idx_of(bus.ld_x, bus.ld_y)] <= bus.ld_tile;
          end else if (bus.hit_valid) begin
            hx     <= bus.hit_x;
            hy     <= bus.hit_y;
            hmask  <= bus.hit_mask;
            hheavy <= bus.hit_heavy;
            state  <= ST_LOOKUP;
          end
        end
        ST_CLEAR: begin
          tiles[clr_idx] <= TILE_AIR;
          if (bus.init)                clr_idx <= '0;
          else if (clr_idx == LAST_IDX) state  <= ST_IDLE;
          else                          clr_idx <= clr_idx + 1'b1;
        end
        ST_LOOKUP: begin
          wr_pend  <= nxt_wr;
          wr_tile  <= nxt_tile;
          res_pend <= nxt_res;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wr_pend) tiles[idx_of(hx, hy)] <= wr_tile;
          done_q   <= 1'b1;
          result_q <= res_pend;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
